// File: rtl/bcd_serial_alu.sv
// Digit-serial 4-digit BCD add/subtract fed by the frame shifter's parallel outputs.
// Latency: done follows 37 edges after frame_start (41 with borrow, 34 on bad digit); no backpressure.
module bcd_serial_alu #(
  parameter int FRAME_LEN = 33,
  parameter int DIGITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] bcd_A,
  input  logic [15:0] bcd_B,
  input  logic        ctrl,
  output logic [15:0] result,
  output logic        carry,
  output logic        neg,
  output logic        err,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SHIFT, CALC, FIX, DONE} state_t;

  localparam logic [5:0] FRAME_CNT  = 6'(FRAME_LEN);
  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [1:0]  idx;
  logic [15:0] op_a, op_b, acc;
  logic        op_sub, bad, cin;

  logic [3:0]  a_term, b_term, digit;
  logic [4:0]  sum, sum_adj;
  logic        cout;
  logic [15:0] acc_shifted;

  function automatic logic has_bad_digit(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (v[i*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // Shared digit adder: operands in CALC, nines' complement of the raw result in FIX.
  always_comb begin
    a_term = op_a[3:0];
    b_term = op_sub ? (4'd9 - op_b[3:0]) : op_b[3:0];
    if (state == FIX) begin
      a_term = 4'd9 - acc[3:0];
      b_term = 4'd0;
    end
    sum     = {1'b0, a_term} + {1'b0, b_term} + {4'd0, cin};
    sum_adj = sum - 5'd10;
    cout    = (sum > 5'd9);
    digit   = cout ? sum_adj[3:0] : sum[3:0];
    acc_shifted = {digit, acc[15:4]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frame_start) state_nxt = SHIFT;
      SHIFT: if (cnt == FRAME_CNT) state_nxt = CALC;
      CALC: begin
        if (bad)
          state_nxt = DONE;
        else if (idx == LAST_DIGIT)
          state_nxt = (!op_sub || cout) ? DONE : FIX;
      end
      FIX:   if (idx == LAST_DIGIT) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      op_sub <= 1'b0;
      bad    <= 1'b0;
      cin    <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (frame_start) cnt <= 6'd1;
        SHIFT: begin
          cnt <= cnt + 6'd1;
          if (cnt == FRAME_CNT) begin
            op_a   <= bcd_A;
            op_b   <= bcd_B;
            op_sub <= ctrl;
            cin    <= ctrl;
            bad    <= has_bad_digit(bcd_A) || has_bad_digit(bcd_B);
            idx    <= '0;
          end
        end
        CALC: begin
          if (bad) begin
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
          end else begin
            acc  <= acc_shifted;
            op_a <= {4'd0, op_a[15:4]};
            op_b <= {4'd0, op_b[15:4]};
            cin  <= cout;
            idx  <= idx + 2'd1;
            if (idx == LAST_DIGIT) begin
              if (!op_sub || cout) begin
                result <= acc_shifted;
                carry  <= op_sub ? 1'b0 : cout;
                neg    <= 1'b0;
                err    <= 1'b0;
                done   <= 1'b1;
              end else begin
                // Borrow out: raw result is A-B+10000, re-complement it in FIX.
                cin <= 1'b1;
                idx <= '0;
              end
            end
          end
        end
        FIX: begin
          acc <= acc_shifted;
          cin <= cout;
          idx <= idx + 2'd1;
          if (idx == LAST_DIGIT) begin
            result <= acc_shifted;
            carry  <= 1'b0;
            neg    <= 1'b1;
            err    <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Bench for bcd_serial_alu: directed plan vectors plus random frames against an integer BCD model.
module tb_bcd_serial_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] bcd_a = '0;
  logic [15:0] bcd_b = '0;
  logic        ctrl = 1'b0;
  logic [15:0] result;
  logic        carry, neg, err, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bcd_serial_alu dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .bcd_A(bcd_a), .bcd_B(bcd_b), .ctrl(ctrl),
    .result(result), .carry(carry), .neg(neg), .err(err),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic nibble_bad(input logic [15:0] v);
    return (v[3:0] > 9) || (v[7:4] > 9) || (v[11:8] > 9) || (v[15:12] > 9);
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) r[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // pulse_at / rst_at: edge count after the start edge at which to inject a stray
  // frame_start or a reset (-1 = never).
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic op,
                           input int pulse_at, input int rst_at);
    logic [15:0] e_res;
    logic        e_carry, e_neg, e_err;
    int          e_lat, ia, ib, n;
    ia = bcd2int(a);
    ib = bcd2int(b);
    e_res = '0; e_carry = 0; e_neg = 0; e_err = 0;
    if (nibble_bad(a) || nibble_bad(b)) begin
      e_err = 1; e_lat = 34;
    end else if (!op) begin
      e_res = int2bcd((ia + ib) % 10000); e_carry = (ia + ib) >= 10000; e_lat = 37;
    end else if (ia >= ib) begin
      e_res = int2bcd(ia - ib); e_lat = 37;
    end else begin
      e_res = int2bcd(ib - ia); e_neg = 1; e_lat = 41;
    end

    @(negedge clk);
    bcd_a = a; bcd_b = b; ctrl = op; frame_start = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && n < 80) begin
      frame_start = (n == pulse_at);
      rst = (n == rst_at);
      @(posedge clk);
      n++;
      @(negedge clk);
      frame_start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk("rst_outputs", {result, carry, neg, err, busy, done}, 21'd0);
        return;
      end
    end
    chk("done_latency", n, e_lat);
    if (done) begin
      chk("result", result, e_res);
      chk("carry", carry, e_carry);
      chk("neg", neg, e_neg);
      chk("err", err, e_err);
      chk("busy_in_done", busy, 1);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
      chk("busy_after_done", busy, 0);
      chk("result_hold", result, e_res);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {result, carry, neg, err, busy, done}, 21'd0);
    rst = 1'b0;

    run_frame(16'h1234, 16'h5678, 1'b0, -1, -1);
    run_frame(16'h9999, 16'h0001, 1'b0, -1, -1);
    run_frame(16'h5000, 16'h5000, 1'b0, -1, -1);
    run_frame(16'h5000, 16'h1234, 1'b1, -1, -1);
    run_frame(16'h0042, 16'h0042, 1'b1, -1, -1);
    run_frame(16'h0100, 16'h0250, 1'b1, -1, -1);
    run_frame(16'h0000, 16'h9999, 1'b1, -1, -1);
    run_frame(16'h12A4, 16'h0001, 1'b0, -1, -1);
    run_frame(16'h0003, 16'h0004, 1'b0, -1, -1);
    // Reset in the middle of the digit loop, then a clean frame.
    run_frame(16'h4321, 16'h1111, 1'b0, -1, 35);
    run_frame(16'h4321, 16'h1111, 1'b0, -1, -1);
    // Stray frame_start pulses during SHIFT and CALC must not disturb the frame.
    run_frame(16'h0100, 16'h0250, 1'b1, 10, -1);
    run_frame(16'h2718, 16'h3141, 1'b0, 35, -1);

    for (int i = 0; i < 24; i++)
      run_frame(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
